ft64_gpu_bus_arbiter: RTL and testbench



---
 rtl/ft64_gpu_bus_arbiter_if.sv | 34 +++
 rtl/ft64_gpu_bus_arbiter.sv | 170 +++++++++++++++++
 tb/tb_ft64_gpu_bus_arbiter.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/ft64_gpu_bus_arbiter_if.sv
// Bus-side signal bundle for the FT64 GPU two-master arbiter.
// The arbiter sits on the slave modport; the requester/mux side uses master.
interface ft64_gpu_bus_arbiter_if;
    logic s1_cyc_i;
    logic s2_cyc_i;
    logic m1_ack_i;
    logic grnt_o;
    logic s1_wait_o;
    logic s2_wait_o;
    logic busy_o;
    logic to_o;

    modport slave (
        input  s1_cyc_i,
        input  s2_cyc_i,
        input  m1_ack_i,
        output grnt_o,
        output s1_wait_o,
        output s2_wait_o,
        output busy_o,
        output to_o
    );

    modport master (
        output s1_cyc_i,
        output s2_cyc_i,
        output m1_ack_i,
        input  grnt_o,
        input  s1_wait_o,
        input  s2_wait_o,
        input  busy_o,
        input  to_o
    );
endinterface

// File: rtl/ft64_gpu_bus_arbiter.sv
// Round-robin grant select for the FT64 GPU bus mux with quantum, gap window and turnaround.
// Optional ack timeout with forced hand-over is enabled by defining GPU_ARB_TIMEOUT_EN.
module ft64_gpu_bus_arbiter #(
    parameter int QUANTUM   = 4,
    parameter int GAP       = 2,
    parameter int TO_CYCLES = 255
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          ce_i,
    ft64_gpu_bus_arbiter_if.slave         bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT  = 2'd1,
        TURN = 2'd2
    } state_t;

    localparam logic [3:0] QUANTUM_L = 4'(QUANTUM);
    localparam logic [3:0] GAP_M1_L  = 4'(GAP - 1);

    state_t     state_q, state_d;
    logic       grnt_q, grnt_d;
    logic       last_q, last_d;
    logic [3:0] qcnt_q, qcnt_d;
    logic [3:0] gcnt_q, gcnt_d;
    logic       own_prev_q;
    logic       s1_wait_q, s1_wait_d;
    logic       s2_wait_q, s2_wait_d;
    logic       busy_q, busy_d;
    logic       to_q, to_d;

    logic       own_cyc;
    logic       oth_cyc;
    logic       own_fall;
    logic       do_switch;
    logic       to_fire;

    assign own_cyc  = grnt_q ? bus.s2_cyc_i : bus.s1_cyc_i;
    assign oth_cyc  = grnt_q ? bus.s1_cyc_i : bus.s2_cyc_i;
    assign own_fall = (state_q == GNT) && own_prev_q && !own_cyc;

`ifdef GPU_ARB_TIMEOUT_EN
    localparam logic [7:0] TO_L = 8'(TO_CYCLES);

    logic [7:0] tocnt_q, tocnt_d;

    // Counter only runs while the owner holds cyc without ack; anything else clears it.
    always_comb begin
        tocnt_d = '0;
        to_fire = 1'b0;
        if (state_q == GNT && own_cyc && !bus.m1_ack_i) begin
            if (tocnt_q + 8'd1 == TO_L) begin
                to_fire = 1'b1;
            end else begin
                tocnt_d = tocnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            tocnt_q <= '0;
        end else if (ce_i) begin
            tocnt_q <= tocnt_d;
        end
    end
`else
    logic unused_timeout;

    assign to_fire        = 1'b0;
    assign unused_timeout = bus.m1_ack_i ^ (TO_CYCLES == 0);
`endif

    // NOTE: every variable gets its default before the case so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        grnt_d    = grnt_q;
        last_d    = last_q;
        qcnt_d    = qcnt_q;
        gcnt_d    = gcnt_q;
        do_switch = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.s1_cyc_i && bus.s2_cyc_i) begin
                    grnt_d  = ~last_q;
                    state_d = GNT;
                end else if (bus.s1_cyc_i) begin
                    grnt_d  = 1'b0;
                    state_d = GNT;
                end else if (bus.s2_cyc_i) begin
                    grnt_d  = 1'b1;
                    state_d = GNT;
                end
            end
            GNT: begin
                if (own_fall && qcnt_q != 4'hF) begin
                    qcnt_d = qcnt_q + 4'd1;
                end
                // The completed transaction is counted before the quantum test below.
                if (to_fire && oth_cyc) begin
                    do_switch = 1'b1;
                end else if (own_cyc || !oth_cyc) begin
                    gcnt_d = '0;
                end else if (qcnt_d >= QUANTUM_L || gcnt_q >= GAP_M1_L) begin
                    do_switch = 1'b1;
                end else begin
                    gcnt_d = gcnt_q + 4'd1;
                end
            end
            TURN: begin
                state_d = GNT;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (do_switch) begin
            grnt_d  = ~grnt_q;
            last_d  = grnt_q;
            qcnt_d  = '0;
            gcnt_d  = '0;
            state_d = TURN;
        end
    end

    always_comb begin
        s1_wait_d = bus.s1_cyc_i & (grnt_q | (state_q == TURN));
        s2_wait_d = bus.s2_cyc_i & (~grnt_q | (state_q == TURN));
        busy_d    = own_cyc & (state_q == GNT);
        to_d      = to_fire;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q    <= IDLE;
            grnt_q     <= 1'b0;
            last_q     <= 1'b1;
            qcnt_q     <= '0;
            gcnt_q     <= '0;
            own_prev_q <= 1'b0;
            s1_wait_q  <= 1'b0;
            s2_wait_q  <= 1'b0;
            busy_q     <= 1'b0;
            to_q       <= 1'b0;
        end else if (ce_i) begin
            state_q    <= state_d;
            grnt_q     <= grnt_d;
            last_q     <= last_d;
            qcnt_q     <= qcnt_d;
            gcnt_q     <= gcnt_d;
            own_prev_q <= own_cyc;
            s1_wait_q  <= s1_wait_d;
            s2_wait_q  <= s2_wait_d;
            busy_q     <= busy_d;
            to_q       <= to_d;
        end
    end

    assign bus.grnt_o    = grnt_q;
    assign bus.s1_wait_o = s1_wait_q;
    assign bus.s2_wait_o = s2_wait_q;
    assign bus.busy_o    = busy_q;
    assign bus.to_o      = to_q;

endmodule

// File: tb/tb_ft64_gpu_bus_arbiter.sv
// Scoreboard bench for ft64_gpu_bus_arbiter: directed per-cycle vectors push expected
// {grnt, s1_wait, s2_wait, busy, to}; a monitor pops and compares after each edge.
module tb_ft64_gpu_bus_arbiter;

    logic clk_i = 1'b0;
    logic rst_i = 1'b0;
    logic ce_i  = 1'b1;

    ft64_gpu_bus_arbiter_if bus ();

    ft64_gpu_bus_arbiter #(
        .QUANTUM  (4),
        .GAP      (2),
        .TO_CYCLES(16)
    ) dut (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .ce_i (ce_i),
        .bus  (bus)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [4:0] exp;
        string      name;
    } exp_t;

    exp_t sb[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    task automatic check(input string name, input logic [4:0] act, input logic [4:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got {grnt,s1w,s2w,busy,to}=%b, expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Inputs change on the falling edge; the expected value is for the following rising edge.
    task automatic step(input logic rst, input logic ce, input logic s1, input logic s2,
                        input logic ack, input logic [4:0] exp, input string name);
        exp_t e;
        @(negedge clk_i);
        rst_i        = rst;
        ce_i         = ce;
        bus.s1_cyc_i = s1;
        bus.s2_cyc_i = s2;
        bus.m1_ack_i = ack;
        e.exp  = exp;
        e.name = name;
        sb.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk_i);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check(e.name, {bus.grnt_o, bus.s1_wait_o, bus.s2_wait_o, bus.busy_o, bus.to_o}, e.exp);
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int guard;
        bus.s1_cyc_i = 1'b0;
        bus.s2_cyc_i = 1'b0;
        bus.m1_ack_i = 1'b0;

        // Reset held with both masters requesting
        step(0, 1, 1, 1, 0, 5'b00000, "reset_hold");
        step(0, 1, 1, 1, 0, 5'b00000, "reset_hold2");

        // Release with both requesting: s1 wins the first tie
        step(1, 1, 1, 1, 0, 5'b00100, "tie_grant_s1");
        step(1, 1, 1, 1, 0, 5'b00110, "s1_busy");

        // s1 completes four transactions while s2 waits; 4th edge hands over
        for (int i = 0; i < 3; i++) begin
            step(1, 1, 0, 1, 0, 5'b00100, "quantum_drop");
            step(1, 1, 1, 1, 0, 5'b00110, "quantum_raise");
        end
        step(1, 1, 0, 1, 0, 5'b10100, "quantum_switch");
        step(1, 1, 0, 1, 0, 5'b10100, "quantum_turn");
        step(1, 1, 0, 1, 0, 5'b10010, "s2_busy");

        // s2 releases, nobody requests: grant parked on s2
        step(1, 1, 0, 0, 0, 5'b10000, "park_s2_a");
        step(1, 1, 0, 0, 0, 5'b10000, "park_s2_b");
        step(1, 1, 0, 0, 0, 5'b10000, "park_s2_c");

        // s1 requests from parked state: gap window, then switch and turnaround
        step(1, 1, 1, 0, 0, 5'b11000, "unpark_gap");
        step(1, 1, 1, 0, 0, 5'b01000, "unpark_switch");
        step(1, 1, 1, 0, 0, 5'b01000, "unpark_turn");
        step(1, 1, 1, 0, 0, 5'b00010, "s1_busy2");

        // s1 re-raises after a one-cycle gap: keeps grant
        step(1, 1, 1, 1, 0, 5'b00110, "s2_waits");
        step(1, 1, 0, 1, 0, 5'b00100, "gap_drop1");
        step(1, 1, 1, 1, 0, 5'b00110, "gap_reraise_keep");

        // s1 drops and stays low: switch two cycles after the drop
        step(1, 1, 0, 1, 0, 5'b00100, "gap_drop2");
        step(1, 1, 0, 1, 0, 5'b10100, "gap_switch");
        step(1, 1, 0, 1, 0, 5'b10100, "gap_turn");
        step(1, 1, 0, 1, 0, 5'b10010, "s2_busy2");

        // Hand back to s1
        step(1, 1, 1, 0, 0, 5'b11000, "back_gap");
        step(1, 1, 1, 0, 0, 5'b01000, "back_switch");
        step(1, 1, 1, 0, 0, 5'b01000, "back_turn");
        step(1, 1, 1, 0, 0, 5'b00010, "s1_busy3");

        // Clock enable low freezes everything mid gap countdown
        step(1, 1, 0, 1, 0, 5'b00100, "ce_gap_start");
        repeat (5) step(1, 0, 0, 1, 0, 5'b00100, "ce_hold");
        step(1, 1, 0, 1, 0, 5'b10100, "ce_resume_switch");
        step(1, 1, 0, 1, 0, 5'b10100, "ce_turn");
        step(1, 1, 0, 1, 0, 5'b10010, "s2_busy3");

        // Give s1 the bus, then hold cyc with no ack while s2 waits
        step(1, 1, 1, 0, 0, 5'b11000, "to_setup_gap");
        step(1, 1, 1, 0, 0, 5'b01000, "to_setup_switch");
        step(1, 1, 1, 0, 0, 5'b01000, "to_setup_turn");
        repeat (15) step(1, 1, 1, 1, 0, 5'b00110, "to_count");
`ifdef GPU_ARB_TIMEOUT_EN
        step(1, 1, 1, 1, 0, 5'b10111, "to_fire_switch");
        step(1, 1, 1, 1, 0, 5'b11100, "to_turn");
        step(1, 1, 1, 1, 0, 5'b11010, "to_s2_busy");
`else
        step(1, 1, 1, 1, 0, 5'b00110, "no_to_hold");
        step(1, 1, 1, 1, 0, 5'b00110, "no_to_hold2");
        step(1, 1, 1, 1, 0, 5'b00110, "no_to_hold3");
`endif

        // Reset mid-tenure, then only s2 requests
        step(0, 1, 1, 1, 0, 5'b00000, "midreset");
        step(1, 1, 0, 1, 0, 5'b10100, "post_reset_s2");
        step(1, 1, 0, 1, 0, 5'b10010, "post_reset_busy");

        guard = 0;
        while (sb.size() > 0 && guard < 10) begin
            @(posedge clk_i);
            guard++;
        end
        #2;
        if (sb.size() > 0) begin
            n_vec++;
            n_miss++;
            $display("FAIL drain: %0d expected entries left, expected 0", sb.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
